// File: rtl/gb_cpu_alu16_seq.sv
// gb_cpu_alu16_seq
// Runs the 16-bit CPU arithmetic ops (ADD HL,rr / INC rr / DEC rr / ADD SP,e8)
// through the shared 8-bit ALU. Each op takes two byte passes, low byte first.
// The block drives the ALU's instruction and carry_in while it is busy. It also
// computes the 16-bit flag results and a flag write mask for the register file.
//
// Ports
//   clk_i              core clock
//   reset_i            synchronous, active-high reset
//   start_i            request, accepted only while ready_o=1
//   op_i[1:0]          0=ADD16 1=INC16 2=DEC16 3=ADDSPE8
//   operand_a_i[15:0]  HL / rr / SP
//   operand_b_i[15:0]  rr for ADD16, [7:0]=e8 for ADDSPE8, ignored otherwise
//   ready_o            high in IDLE and DONE
//   done_o             one-cycle pulse, result/flags valid
//   result_o[15:0]     16-bit result, held until the next op completes
//   flag_z/n/h/c_o     computed flags, held with the result
//   flag_we_o[3:0]     {Z,N,H,C} write mask, held with the result
//   alu_instruction_o  {opcode[3:0], operand_a[7:0], operand_b[7:0]} to the ALU
//   alu_carry_in_o     ALU carry_in
//   alu_out_i[7:0]     ALU result byte
//   alu_c_i            ALU carry flag
module gb_cpu_alu16_seq #(
  parameter int PASS_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [15:0] operand_a_i,
  input  logic [15:0] operand_b_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [15:0] result_o,
  output logic        flag_z_o,
  output logic        flag_n_o,
  output logic        flag_h_o,
  output logic        flag_c_o,
  output logic [3:0]  flag_we_o,
  output logic [19:0] alu_instruction_o,
  output logic        alu_carry_in_o,
  input  logic [7:0]  alu_out_i,
  input  logic        alu_c_i
);

  if (PASS_CYCLES < 1 || PASS_CYCLES > 4) begin : g_bad_pass_cycles
    $error("gb_cpu_alu16_seq: PASS_CYCLES must be in 1..4");
  end

  localparam logic [3:0] ALU_OP_ADD = 4'h0;
  localparam logic [1:0] OP_ADD16   = 2'd0;
  localparam logic [1:0] OP_INC16   = 2'd1;
  localparam logic [1:0] OP_DEC16   = 2'd2;
  localparam logic [1:0] OP_ADDSPE8 = 2'd3;
  localparam logic [1:0] CNT_LOAD   = 2'(PASS_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] b_eff_d;
  logic        cy_lo_q;
  logic [7:0]  res_lo_q;
  logic [15:0] result_q;
  logic        z_q, n_q, h_q, c_q;
  logic [3:0]  we_q;
  logic        z_d, n_d, h_d, c_d;
  logic [3:0]  we_d;
  logic [12:0] sum12;
  logic [16:0] sum16;
  logic [4:0]  sum4;
  logic [8:0]  sum8;
  logic        accept;
  logic        last_pass;

  assign ready_o   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign done_o    = (state_q == S_DONE);
  assign accept    = ready_o && start_i;
  assign last_pass = (cnt_q == 2'd0);

  // The second operand is stored already expanded to the {b_hi,b_lo} pair
  // the two passes feed the ALU. INC/DEC become an add of +1 or -1, and e8 is
  // sign-extended into the high byte.
  always_comb begin
    b_eff_d = operand_b_i;
    case (op_i)
      OP_ADD16:   b_eff_d = operand_b_i;
      OP_INC16:   b_eff_d = 16'h0001;
      OP_DEC16:   b_eff_d = 16'hFFFF;
      OP_ADDSPE8: b_eff_d = {{8{operand_b_i[7]}}, operand_b_i[7:0]};
      default:    b_eff_d = operand_b_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Each pass reloads the down-counter and holds for PASS_CYCLES cycles.
  // The pass ends when the counter reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_LO;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 2'd0;
        end
      end
      S_LO: begin
        if (last_pass) begin
          state_d = S_HI;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_HI: begin
        if (last_pass) begin
          state_d = S_DONE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // The flags come straight from the latched operands, so the ALU's own
  // 8-bit H flag never has to be interpreted in 16-bit terms.
  always_comb begin
    sum12 = {1'b0, a_q[11:0]} + {1'b0, b_q[11:0]};
    sum16 = {1'b0, a_q} + {1'b0, b_q};
    sum4  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]};
    sum8  = {1'b0, a_q[7:0]} + {1'b0, b_q[7:0]};
    z_d   = 1'b0;
    n_d   = 1'b0;
    h_d   = 1'b0;
    c_d   = 1'b0;
    we_d  = 4'b0000;
    case (op_q)
      OP_ADD16: begin
        h_d  = sum12[12];
        c_d  = sum16[16];
        we_d = 4'b0111;
      end
      OP_ADDSPE8: begin
        h_d  = sum4[4];
        c_d  = sum8[8];
        we_d = 4'b1111;
      end
      default: begin
        we_d = 4'b0000;
      end
    endcase
  end

  // The low byte is parked in res_lo_q. The visible result and flags change
  // together on the edge into DONE, so they never show a half-finished value.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_q     <= 2'd0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      cy_lo_q  <= 1'b0;
      res_lo_q <= 8'h00;
      result_q <= 16'h0000;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      h_q      <= 1'b0;
      c_q      <= 1'b0;
      we_q     <= 4'b0000;
    end else begin
      if (accept) begin
        op_q <= op_i;
        a_q  <= operand_a_i;
        b_q  <= b_eff_d;
      end
      if (state_q == S_LO && last_pass) begin
        res_lo_q <= alu_out_i;
        cy_lo_q  <= alu_c_i;
      end
      if (state_q == S_HI && last_pass) begin
        result_q <= {alu_out_i, res_lo_q};
        z_q      <= z_d;
        n_q      <= n_d;
        h_q      <= h_d;
        c_q      <= c_d;
        we_q     <= we_d;
      end
    end
  end

  always_comb begin
    alu_instruction_o = {ALU_OP_ADD, 8'h00, 8'h00};
    alu_carry_in_o    = 1'b0;
    case (state_q)
      S_LO: begin
        alu_instruction_o = {ALU_OP_ADD, a_q[7:0], b_q[7:0]};
        alu_carry_in_o    = 1'b0;
      end
      S_HI: begin
        alu_instruction_o = {ALU_OP_ADD, a_q[15:8], b_q[15:8]};
        alu_carry_in_o    = cy_lo_q;
      end
      default: begin
        alu_instruction_o = {ALU_OP_ADD, 8'h00, 8'h00};
        alu_carry_in_o    = 1'b0;
      end
    endcase
  end

  assign result_o  = result_q;
  assign flag_z_o  = z_q;
  assign flag_n_o  = n_q;
  assign flag_h_o  = h_q;
  assign flag_c_o  = c_q;
  assign flag_we_o = we_q;

endmodule

// File: tb/tb_gb_cpu_alu16_seq.sv
// Testbench for gb_cpu_alu16_seq.
// Two instances are built: one with PASS_CYCLES=1 and one with PASS_CYCLES=3.
// Each instance has its own 8-bit adder standing in for the ALU. A reference
// model computes the 16-bit results and flags with plain integer arithmetic.
// Expected completions go into a per-instance queue when a start is accepted.
// A separate monitor pops the queue whenever done is seen.
module tb_gb_cpu_alu16_seq;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  blo;
    logic [7:0]  bhi;
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        h;
    logic        c;
    logic [3:0]  we;
    logic        cinHi;
    int          due;
  } exp_t;

  logic clk;
  logic reset;
  logic checkEn;
  int   nChecks;
  int   nFails;

  logic        start_s [2];
  logic [1:0]  op_s    [2];
  logic [15:0] a_s     [2];
  logic [15:0] b_s     [2];
  logic        ready_s [2];
  logic        done_s  [2];
  logic [15:0] result_s[2];
  logic        z_s     [2];
  logic        n_s     [2];
  logic        h_s     [2];
  logic        c_s     [2];
  logic [3:0]  we_s    [2];
  logic [19:0] ins_s   [2];
  logic        cin_s   [2];
  logic [7:0]  aluo_s  [2];
  logic        aluc_s  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int inst, input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL inst%0d %s: got %0h expected %0h at %0t", inst, name, got, exp, $time);
    end
  endtask

  // Reference behaviour, written from the op definitions as integer sums.
  function automatic exp_t refModel(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [7:0] e8;
    e = '0;
    e.a = a;
    e8 = b[7:0];
    case (op)
      2'd0: begin
        e.blo = b[7:0];
        e.bhi = b[15:8];
        e.res = 16'(int'(a) + int'(b));
        e.h   = (int'(a & 16'h0FFF) + int'(b & 16'h0FFF)) > 'hFFF;
        e.c   = (int'(a) + int'(b)) > 'hFFFF;
        e.we  = 4'b0111;
      end
      2'd1: begin
        e.blo = 8'h01;
        e.bhi = 8'h00;
        e.res = 16'(int'(a) + 1);
      end
      2'd2: begin
        e.blo = 8'hFF;
        e.bhi = 8'hFF;
        e.res = 16'(int'(a) - 1);
      end
      default: begin
        e.blo = e8;
        e.bhi = e8[7] ? 8'hFF : 8'h00;
        e.res = 16'(int'(a) + int'($signed(e8)));
        e.h   = (int'(a & 16'h000F) + int'(e8 & 8'h0F)) > 'hF;
        e.c   = (int'(a & 16'h00FF) + int'(e8)) > 'hFF;
        e.we  = 4'b1111;
      end
    endcase
    e.cinHi = (int'(a[7:0]) + int'(e.blo)) > 255;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int P = (g == 0) ? 1 : 3;

    exp_t expq[$];
    exp_t cur;
    exp_t held;
    int   cnt;
    int   pcyc;

    gb_cpu_alu16_seq #(.PASS_CYCLES(P)) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .start_i          (start_s[g]),
      .op_i             (op_s[g]),
      .operand_a_i      (a_s[g]),
      .operand_b_i      (b_s[g]),
      .ready_o          (ready_s[g]),
      .done_o           (done_s[g]),
      .result_o         (result_s[g]),
      .flag_z_o         (z_s[g]),
      .flag_n_o         (n_s[g]),
      .flag_h_o         (h_s[g]),
      .flag_c_o         (c_s[g]),
      .flag_we_o        (we_s[g]),
      .alu_instruction_o(ins_s[g]),
      .alu_carry_in_o   (cin_s[g]),
      .alu_out_i        (aluo_s[g]),
      .alu_c_i          (aluc_s[g])
    );

    assign {aluc_s[g], aluo_s[g]} = {1'b0, ins_s[g][15:8]} + {1'b0, ins_s[g][7:0]} + {8'd0, cin_s[g]};

    // Acceptance model: a start is taken whenever no op is in flight.
    // An op occupies 2*P cycles of passes, then presents its result.
    initial begin
      cnt  = 0;
      pcyc = 0;
      held = '0;
      cur  = '0;
      forever begin
        @(posedge clk);
        pcyc++;
        if (reset) begin
          cnt = 0;
          expq.delete();
          held = '0;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) held = cur;
        end else if (start_s[g]) begin
          cur = refModel(op_s[g], a_s[g], b_s[g]);
          cur.due = pcyc + 2 * P;
          expq.push_back(cur);
          cnt = 2 * P;
        end
      end
    end

    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        if (checkEn) begin
          check(g, "ready", {63'd0, ready_s[g]}, {63'd0, cnt == 0});
          if (done_s[g]) begin
            if (expq.size() == 0) begin
              check(g, "done_unexpected", 64'd1, 64'd0);
            end else begin
              e = expq.pop_front();
              check(g, "done_cycle", 64'(pcyc), 64'(e.due));
              check(g, "result", {48'd0, result_s[g]}, {48'd0, e.res});
              check(g, "flags_we", {56'd0, z_s[g], n_s[g], h_s[g], c_s[g], we_s[g]},
                    {56'd0, e.z, e.n, e.h, e.c, e.we});
            end
          end else if (expq.size() > 0 && expq[0].due <= pcyc) begin
            e = expq.pop_front();
            check(g, "done_missing", 64'd0, 64'd1);
          end
          check(g, "held_outputs", {40'd0, result_s[g], z_s[g], n_s[g], h_s[g], c_s[g], we_s[g]},
                {40'd0, held.res, held.z, held.n, held.h, held.c, held.we});
          if (cnt == 0) begin
            check(g, "alu_idle", {43'd0, ins_s[g], cin_s[g]}, {43'd0, 20'h00000, 1'b0});
          end else if (cnt > P) begin
            check(g, "alu_lo", {43'd0, ins_s[g], cin_s[g]}, {43'd0, 4'h0, cur.a[7:0], cur.blo, 1'b0});
          end else begin
            check(g, "alu_hi", {43'd0, ins_s[g], cin_s[g]}, {43'd0, 4'h0, cur.a[15:8], cur.bhi, cur.cinHi});
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int i, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int w;
    w = 0;
    while (!ready_s[i] && w < 50) begin
      @(negedge clk);
      w++;
    end
    check(i, "ready_wait", {63'd0, w < 50}, 64'd1);
    op_s[i]    = op;
    a_s[i]     = a;
    b_s[i]     = b;
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
  endtask

  task automatic runInstance(input int i);
    int p;
    p = (i == 0) ? 1 : 3;
    applyStimulus(i, 2'd0, 16'h0FFF, 16'h0001);
    applyStimulus(i, 2'd0, 16'h8000, 16'h8000);
    applyStimulus(i, 2'd1, 16'hFFFF, 16'h5A5A);
    applyStimulus(i, 2'd2, 16'h0000, 16'hA5A5);
    applyStimulus(i, 2'd3, 16'hFFF8, 16'h0008);
    applyStimulus(i, 2'd3, 16'h0005, 16'h00FE);
    for (int k = 0; k < 25; k++) begin
      applyStimulus(i, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (2 * p + 4) @(negedge clk);
    // Hold start high: only IDLE and each DONE cycle may take a new op.
    start_s[i] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      op_s[i] = 2'($urandom_range(0, 3));
      a_s[i]  = 16'($urandom);
      b_s[i]  = 16'($urandom);
      @(negedge clk);
    end
    start_s[i] = 1'b0;
    repeat (2 * p + 4) @(negedge clk);
    // Reset while the high-byte pass is running aborts the op silently.
    applyStimulus(i, 2'd0, 16'h1234, 16'h4321);
    repeat (p) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2 * p + 4) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    nChecks = 0;
    nFails  = 0;
    checkEn = 1'b0;
    reset   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      op_s[i]    = 2'd0;
      a_s[i]     = 16'h0000;
      b_s[i]     = 16'h0000;
    end
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    checkEn = 1'b1;
    @(negedge clk);
    runInstance(0);
    runInstance(1);
    repeat (10) @(negedge clk);
    check(0, "queue_drained", 64'(g_inst[0].expq.size()), 64'd0);
    check(1, "queue_drained", 64'(g_inst[1].expq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
